// File: rtl/request_queue_pkg.sv
// global_defs: request struct, opcode encoding and default sizing shared by
// the trace parser, request_queue and the memory-controller scheduler.
package global_defs;
    localparam int DEFAULT_DEPTH         = 16;
    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int CLK_COUNT_WIDTH       = 64;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        IFETCH = 2'd2
    } opcode_e;

    // opcode stays a raw 2-bit field so the reserved encoding 3 passes through untouched
    typedef struct packed {
        logic [CLK_COUNT_WIDTH-1:0]       CPU_clock_count;
        logic [1:0]                       opcode;
        logic [DEFAULT_ADDRESS_WIDTH-1:0] address;
        logic                             op_ready_s;
    } parser_out_struct;
endpackage

// File: rtl/request_queue.sv
// request_queue: bounded in-order circular-buffer queue of parser requests for the scheduler.
// Define QUEUE_DEBUG_EN for a simulation-only push/pop/occupancy monitor with sanity assertions.
module request_queue
    import global_defs::*;
#(
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                   CPU_clock,
    input  logic                   rst_n,
    input  parser_out_struct       parser_output,
    input  logic                   exit_flag,
    output parser_out_struct       fifo_output,
    output logic                   full,
    output logic                   empty,
    output logic                   insert_flag,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    // the struct layout is fixed by the shared package, so the address width cannot diverge here
    if (ADDRESS_WIDTH != DEFAULT_ADDRESS_WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("request_queue: unsupported DEPTH/ADDRESS_WIDTH configuration");
    end

    parser_out_struct r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_insert;
    logic             w_push;
    logic             w_pop;

    assign full        = r_count == (PW + 1)'(DEPTH);
    assign empty       = r_count == '0;
    assign w_push      = parser_output.op_ready_s & (~full | exit_flag);
    assign w_pop       = exit_flag & ~empty;
    assign fifo_output = r_mem[r_rd_ptr];
    assign insert_flag = r_insert;
    assign count       = r_count;

    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_insert <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop);
            r_insert <= w_push;
        end
    end

    // storage is not reset; a write during reset is harmless because wr_ptr and count restart
    always_ff @(posedge CPU_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= parser_output;
    end

`ifdef QUEUE_DEBUG_EN
`ifndef SYNTHESIS
    always @(posedge CPU_clock) begin
        if (rst_n) begin
            if (w_push)
                $display("%0t request_queue push clk=%0d op=%0d addr=%h", $time,
                         parser_output.CPU_clock_count, parser_output.opcode, parser_output.address);
            if (w_pop)
                $display("%0t request_queue pop  clk=%0d op=%0d addr=%h", $time,
                         fifo_output.CPU_clock_count, fifo_output.opcode, fifo_output.address);
            $display("%0t request_queue count=%0d", $time, r_count);
            assert (r_count <= (PW + 1)'(DEPTH)) else $error("request_queue: count exceeds DEPTH");
            assert (!(w_push && full && !w_pop)) else $error("request_queue: push accepted while full");
        end
    end
`endif
`else
`endif
endmodule

// File: tb/tb_request_queue.sv
// tb_request_queue: directed plan plus randomized traffic, checked cycle by cycle
// against a queue-based reference model of the request queue.
module tb_request_queue;
    import global_defs::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic             CPU_clock = 1'b0;
    logic             rst_n     = 1'b0;
    parser_out_struct parser_output = '0;
    logic             exit_flag = 1'b0;
    parser_out_struct fifo_output;
    logic             full;
    logic             empty;
    logic             insert_flag;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    parser_out_struct m_q[$];
    bit               m_ins = 1'b0;
    longint unsigned  stamp = 0;

    request_queue #(.DEPTH(DEPTH), .ADDRESS_WIDTH(DEFAULT_ADDRESS_WIDTH)) dut (
        .CPU_clock    (CPU_clock),
        .rst_n        (rst_n),
        .parser_output(parser_output),
        .exit_flag    (exit_flag),
        .fifo_output  (fifo_output),
        .full         (full),
        .empty        (empty),
        .insert_flag  (insert_flag),
        .count        (count)
    );

    always #5 CPU_clock = ~CPU_clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic parser_out_struct mk(input logic [1:0] op, input logic [31:0] addr, input logic rdy);
        parser_out_struct p;
        p.CPU_clock_count = 64'(stamp);
        p.opcode          = op;
        p.address         = addr;
        p.op_ready_s      = rdy;
        return p;
    endfunction

    // one clock: drive, advance, update the model from the queue rules, compare everything
    task automatic cycle(input parser_out_struct p, input logic ex, input logic rn);
        bit push, pop;
        parser_output = p;
        exit_flag     = ex;
        rst_n         = rn;
        @(posedge CPU_clock);
        #1;
        stamp++;
        if (!rn) begin
            m_q.delete();
            m_ins = 1'b0;
        end else begin
            push = p.op_ready_s && (m_q.size() < DEPTH || ex);
            pop  = ex && m_q.size() > 0;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(p);
            m_ins = push;
        end
        chk("count", 128'(count), 128'(m_q.size()));
        chk("empty", 128'(empty), 128'(m_q.size() == 0));
        chk("full", 128'(full), 128'(m_q.size() == DEPTH));
        chk("insert_flag", 128'(insert_flag), 128'(m_ins));
        if (m_q.size() > 0) chk("head", 128'(fifo_output), 128'(m_q[0]));
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic ex);
        cycle(mk(op, addr, 1'b1), ex, 1'b1);
    endtask

    task automatic idle(input logic ex);
        cycle(mk(2'd0, 32'h0, 1'b0), ex, 1'b1);
    endtask

    initial begin
        cycle(mk(2'd1, 32'h5555_0000, 1'b1), 1'b0, 1'b0);
        cycle(mk(2'd1, 32'h5555_0004, 1'b1), 1'b0, 1'b0);
        chk("reset_empty", 128'(empty), 128'd1);
        chk("reset_count", 128'(count), 128'd0);

        stamp = 10;
        cycle(mk(2'd1, 32'h0000_1A40, 1'b1), 1'b0, 1'b1);
        chk("single_addr", 128'(fifo_output.address), 128'h1A40);
        chk("single_op", 128'(fifo_output.opcode), 128'd1);
        chk("single_stamp", 128'(fifo_output.CPU_clock_count), 128'd10);
        idle(1'b0);
        chk("single_ins_drop", 128'(insert_flag), 128'd0);
        idle(1'b1);

        for (int i = 0; i < DEPTH; i++) push(2'(i), 32'h100 + 32'(i), 1'b0);
        chk("fill_full", 128'(full), 128'd1);
        push(2'd0, 32'h110, 1'b0);
        chk("reject_ins", 128'(insert_flag), 128'd0);
        chk("reject_head", 128'(fifo_output.address), 128'h100);

        push(2'd2, 32'h200, 1'b1);
        chk("simul_count", 128'(count), 128'd16);
        chk("simul_head", 128'(fifo_output.address), 128'h101);
        for (int i = 0; i < DEPTH - 1; i++) idle(1'b1);
        chk("wrap_head", 128'(fifo_output.address), 128'h200);
        idle(1'b1);
        chk("drained", 128'(empty), 128'd1);
        idle(1'b1);
        chk("pop_empty", 128'(count), 128'd0);
        push(2'd3, 32'h300, 1'b1);
        chk("pushpop_empty", 128'(count), 128'd1);
        chk("pushpop_head", 128'(fifo_output.address), 128'h300);
        idle(1'b1);

        for (int i = 0; i < 5; i++) push(2'd0, 32'h400 + 32'(i), 1'b0);
        chk("pre_reset", 128'(count), 128'd5);
        cycle(mk(2'd1, 32'h500, 1'b1), 1'b1, 1'b0);
        chk("midreset_count", 128'(count), 128'd0);
        chk("midreset_empty", 128'(empty), 128'd1);
        push(2'd1, 32'hDEAD_BEE0, 1'b0);
        chk("after_reset_head", 128'(fifo_output.address), 128'hDEAD_BEE0);

        // phases bias towards filling or draining so both boundaries get hit repeatedly
        for (int i = 0; i < 3000; i++) begin
            int pr, pe;
            pr = ((i / 200) % 2 == 0) ? 80 : 30;
            pe = ((i / 200) % 2 == 0) ? 30 : 80;
            cycle(mk(2'($urandom), $urandom, 1'($urandom_range(99) < pr)),
                  1'($urandom_range(99) < pe),
                  1'($urandom_range(299) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/request_queue.md
Name: request_queue

Overview:
- Bounded, in-order queue of decoded memory requests between the trace parser (upstream) and the memory-controller scheduler (downstream).
- Each cycle it accepts at most one request struct whose ready bit is set, and presents the oldest entry combinationally at its head.
- Reports full/empty, occupancy and a per-cycle insert acknowledge.
- Single clock domain, synthesizable storage (circular buffer, no dynamic queues).

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- ADDRESS_WIDTH, 32, width of the request address field.

Ports:
- CPU_clock  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the CPU_clock rising edge.
- parser_output  in  parser_out_struct  incoming request; push is qualified by the field op_ready_s.
- exit_flag  in  1  pop request from downstream; removes the head at the clock edge.
- fifo_output  out  parser_out_struct  head entry, combinational from storage; valid when empty=0.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- insert_flag  out  1  registered; high for exactly the cycle after a push was accepted.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- parser_out_struct fields, in order:
  - CPU_clock_count[63:0]
  - opcode[1:0] (0 data read, 1 data write, 2 instruction fetch, 3 reserved)
  - address[ADDRESS_WIDTH-1:0]
  - op_ready_s (1 bit).
- Storage: DEPTH-entry array, write pointer wr_ptr, read pointer rd_ptr, each log2(DEPTH) bits, plus count.
- Pointers wrap modulo DEPTH; full/empty are derived from count, not from pointer equality.
- Reset (rst_n=0 at an edge):
  - wr_ptr=rd_ptr=0, count=0.
  - empty=1, full=0, insert_flag=0.
  - Array contents are don't-care.
  - Reset mid-operation discards all entries on that edge; any push or pop in the same cycle is ignored.
- push_ok = parser_output.op_ready_s & (~full | exit_flag).
- pop_ok = exit_flag & ~empty.
- Push: the struct is written at wr_ptr, wr_ptr++.
  - The stored op_ready_s is kept as presented (always 1).
- Pop: rd_ptr++.
- count update: count +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Full and exit_flag=1: push and pop both occur in the same cycle; count stays DEPTH.
- Empty: exit_flag is ignored. If a push happens in the same cycle, the entry is stored and becomes the head next cycle (no fall-through).
- Full without pop: the push is rejected and insert_flag=0 next cycle.
  - Upstream must hold op_ready_s and the struct stable until it sees insert_flag=1.
  - Each cycle op_ready_s=1 with push_ok is one distinct push, so upstream must deassert op_ready_s after acceptance.
- fifo_output = array[rd_ptr] at all times; the value is undefined when empty=1.
- Latency: a pushed entry is visible at the head 1 cycle after the push edge, provided it is the oldest entry.
- Order: strict FIFO, no reordering or coalescing; duplicate addresses are stored separately.

Optional Feature:
- QUEUE_DEBUG_EN defined: simulation-only monitor (non-synthesizable block excluded under synthesis).
  - On every accepted push or pop, prints time, the event, the CPU_clock_count, opcode and address.
  - Each cycle, prints count.
  - Asserts an error if count>DEPTH or if a push is accepted while full without a pop.
- Not defined: no monitor, no prints or assertions. Ports and RTL are identical.

Decomposition:
- Package global_defs holds:
  - parser_out_struct
  - an opcode enum (READ=0, WRITE=1, IFETCH=2)
  - ADDRESS_WIDTH and DEPTH defaults
  - CPU clock-count width (64).
- The parser and the scheduler import the same package.
- No sub-module required; the pointer/count logic stays inline in request_queue.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with op_ready_s=1 -> empty=1, full=0, count=0, insert_flag=0; nothing stored.
- Single push: {clk 10, opcode 1, addr 32'h0000_1A40, ready 1} for 1 cycle -> next cycle insert_flag=1, count=1, empty=0, fifo_output.address=32'h0000_1A40, opcode=1.
- Fill: push 16 distinct addresses 32'h100..32'h10F -> full=1 after the 16th. A 17th push with exit_flag=0 -> insert_flag=0, count=16; head still 32'h100.
- Full simultaneous: push 32'h200 with exit_flag=1 while full -> count=16, head becomes 32'h101. After 15 more pops the head is 32'h200 (wrap-around ordering).
- Drain: pop until empty=1 -> exit_flag=1 on an empty queue leaves count=0 and pointers unchanged. Push+pop on empty -> count=1.
- Mid-operation reset: count=5, assert rst_n=0 -> next edge count=0, empty=1. A subsequent push of 32'hDEAD_BEE0 appears at the head.
